ballot_controller: RTL and testbench

BALLOT_CONTROLLER -- requirements
Module: ballot_controller

---
 rtl/ballot_controller_if.sv | 30 +++
 rtl/ballot_controller.sv | 198 +++++++++++++++++++
 tb/tb_ballot_controller.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ballot_controller_if.sv
// Ballot controller signal bundle: raw buttons and officer controls in, vote pulses and status out.
// Pure wiring, no storage; the controller drives every output from a flop.
// No backpressure: vote pulses are fire-and-forget to the tally stage.
interface ballot_controller_if;
  logic       btn_c1;
  logic       btn_c2;
  logic       btn_c3;
  logic       voter_auth;
  logic       close_poll;
  logic       vote_c1;
  logic       vote_c2;
  logic       vote_c3;
  logic       ready;
  logic       multi_press;
  logic       timeout;
  logic       closed;
  logic [7:0] ballot_count;

  // Stimulus side (officer console / buttons / tally consumer)
  modport master (
    output btn_c1, btn_c2, btn_c3, voter_auth, close_poll,
    input  vote_c1, vote_c2, vote_c3, ready, multi_press, timeout, closed, ballot_count
  );

  // Controller side
  modport slave (
    input  btn_c1, btn_c2, btn_c3, voter_auth, close_poll,
    output vote_c1, vote_c2, vote_c3, ready, multi_press, timeout, closed, ballot_count
  );
endinterface

// File: rtl/ballot_controller.sv
// Voting-booth controller: sync + debounce three buttons, arm one ballot per voter_auth, emit one vote pulse.
// Latency: clean press sampled at edge 0 -> vote pulse registered at edge DEBOUNCE_CYCLES+3 (FSM must be ARMED).
// No backpressure: downstream tally must accept every one-cycle vote pulse; extra presses are dropped.
module ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 8,
  parameter int ARM_TIMEOUT     = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  ballot_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAST    = 3'd2,
    LOCKOUT = 3'd3,
    CLOSED  = 3'd4
  } state_t;

  localparam logic [7:0]  DB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]  LK_LAST = 8'(LOCKOUT_CYCLES - 1);
  localparam logic [15:0] TO_LAST = 16'(ARM_TIMEOUT - 1);

  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]      deb_q, deb_d, deb_prev_q, deb_prev_d;
  logic [2:0][7:0] db_cnt_q, db_cnt_d;
  logic [2:0]      press_q, press_d;
  logic            press_one, press_multi;

  state_t          state_q, state_d;
  logic [2:0]      cand_q, cand_d;
  logic [15:0]     tmo_q, tmo_d;
  logic [7:0]      lk_q, lk_d;

  logic [2:0]      vote_q, vote_d;
  logic            ready_q, ready_d;
  logic            multi_press_q, multi_press_d;
  logic            timeout_q, timeout_d;
  logic            closed_q, closed_d;
  logic [7:0]      ballot_count_q, ballot_count_d;

  assign btn_raw = {bus.btn_c3, bus.btn_c2, bus.btn_c1};

  // Button front end: 2-flop sync, restartable stability counter, rising-edge press pulse
  always_comb begin
    sync1_d    = btn_raw;
    sync2_d    = sync1_q;
    deb_d      = deb_q;
    db_cnt_d   = '0;
    deb_prev_d = deb_q;
    for (int i = 0; i < 3; i++) begin
      // Count only while the synced level disagrees with the accepted level; a flip back clears it
      if (sync2_q[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
    press_d = deb_q & ~deb_prev_q;
  end

  // Front-end registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      db_cnt_q   <= '0;
      press_q    <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
    end
  end

  assign press_one   = $onehot(press_q);
  assign press_multi = (press_q != 3'b000) && !press_one;

  // FSM state and its counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q  <= '0;
      tmo_q   <= '0;
      lk_q    <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      tmo_q   <= tmo_d;
      lk_q    <= lk_d;
    end
  end

  // Next-state: presses only matter in ARMED; close_poll overrides everything
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    tmo_d   = tmo_q;
    lk_d    = lk_q;
    unique case (state_q)
      IDLE: begin
        if (bus.voter_auth && (ballot_count_q != 8'hFF)) begin
          state_d = ARMED;
          tmo_d   = '0;
        end
      end
      ARMED: begin
        // A single press wins even on the last armed cycle; a multi-press keeps the timer running
        if (press_one) begin
          state_d = CAST;
          cand_d  = press_q;
        end else if (tmo_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      CAST: begin
        state_d = LOCKOUT;
        lk_d    = '0;
      end
      LOCKOUT: begin
        if (lk_q == LK_LAST) begin
          state_d = IDLE;
        end else begin
          lk_d = lk_q + 8'd1;
        end
      end
      CLOSED:  state_d = CLOSED;
      default: state_d = IDLE;
    endcase
    if (bus.close_poll) begin
      state_d = CLOSED;
    end
  end

  // Output decode from the upcoming state so every output is a flop aligned with the state
  always_comb begin
    vote_d         = '0;
    multi_press_d  = 1'b0;
    timeout_d      = 1'b0;
    ready_d        = (state_d == ARMED);
    closed_d       = (state_d == CLOSED);
    ballot_count_d = ballot_count_q;
    if (state_d == CAST) begin
      vote_d = cand_d;
      if (ballot_count_q != 8'hFF) begin
        ballot_count_d = ballot_count_q + 8'd1;
      end
    end
    if ((state_q == ARMED) && (state_d == ARMED) && press_multi) begin
      multi_press_d = 1'b1;
    end
    // The only ARMED->IDLE path is expiry
    if ((state_q == ARMED) && (state_d == IDLE)) begin
      timeout_d = 1'b1;
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_q         <= '0;
      ready_q        <= 1'b0;
      multi_press_q  <= 1'b0;
      timeout_q      <= 1'b0;
      closed_q       <= 1'b0;
      ballot_count_q <= '0;
    end else begin
      vote_q         <= vote_d;
      ready_q        <= ready_d;
      multi_press_q  <= multi_press_d;
      timeout_q      <= timeout_d;
      closed_q       <= closed_d;
      ballot_count_q <= ballot_count_d;
    end
  end

  assign bus.vote_c1      = vote_q[0];
  assign bus.vote_c2      = vote_q[1];
  assign bus.vote_c3      = vote_q[2];
  assign bus.ready        = ready_q;
  assign bus.multi_press  = multi_press_q;
  assign bus.timeout      = timeout_q;
  assign bus.closed       = closed_q;
  assign bus.ballot_count = ballot_count_q;

endmodule

// File: tb/tb_ballot_controller.sv
// Directed bench for ballot_controller with a vote scoreboard.
module tb_ballot_controller;

  typedef struct packed {
    logic [2:0] vote;
    logic [7:0] count;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [2:0] vote_vec;

  ballot_controller_if bus();

  ballot_controller #(
    .DEBOUNCE_CYCLES(4),
    .LOCKOUT_CYCLES (8),
    .ARM_TIMEOUT    (20)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  assign vote_vec = {bus.vote_c3, bus.vote_c2, bus.vote_c1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic arm();
    bus.voter_auth = 1'b1;
    step(1);
    bus.voter_auth = 1'b0;
  endtask

  // Scoreboard: every vote pulse must match the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (vote_vec != 3'b000) begin
      total++;
      assert (sb.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_vote: observed=%b expected=none", vote_vec);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        assert ((vote_vec === e.vote) && (bus.ballot_count === e.count)) else begin
          bad++;
          $error("FAIL vote_sb: observed vote=%b count=%0d expected vote=%b count=%0d",
                 vote_vec, bus.ballot_count, e.vote, e.count);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n          = 1'b0;
    bus.btn_c1     = 1'b0;
    bus.btn_c2     = 1'b0;
    bus.btn_c3     = 1'b0;
    bus.voter_auth = 1'b0;
    bus.close_poll = 1'b0;
    #1;
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_closed", 32'(bus.closed), 0);
    chk("rst_count", 32'(bus.ballot_count), 0);
    chk("rst_votes", 32'(vote_vec), 0);
    chk("rst_pulses", 32'({bus.multi_press, bus.timeout}), 0);
    step(2);
    rst_n = 1'b1;
    step(2);

    // Clean c2 press; lockout length; held buttons; voter_auth while ARMED; timeout
    arm();
    chk("t1_ready", 32'(bus.ready), 1);
    bus.btn_c2 = 1'b1;
    sb.push_back('{vote: 3'b010, count: 8'd1});
    step(7);
    chk("t1_vote_early", 32'(vote_vec), 0);
    step(1);
    chk("t1_vote", 32'(vote_vec), 32'(3'b010));
    chk("t1_count", 32'(bus.ballot_count), 1);
    chk("t1_ready_cast", 32'(bus.ready), 0);
    step(1);
    chk("t1_vote_one_cycle", 32'(vote_vec), 0);
    bus.btn_c1 = 1'b1;
    step(7);
    bus.voter_auth = 1'b1;
    step(1);
    chk("t1_auth_in_lockout", 32'(bus.ready), 0);
    step(1);
    chk("t1_auth_after_lockout", 32'(bus.ready), 1);
    bus.voter_auth = 1'b0;
    step(2);
    bus.voter_auth = 1'b1;
    step(1);
    bus.voter_auth = 1'b0;
    chk("t1_rearm_ready", 32'(bus.ready), 1);
    step(16);
    chk("t1_timeout_early", 32'(bus.timeout), 0);
    chk("t1_ready_before_to", 32'(bus.ready), 1);
    step(1);
    chk("t1_timeout", 32'(bus.timeout), 1);
    chk("t1_ready_after_to", 32'(bus.ready), 0);
    chk("t1_count_after_to", 32'(bus.ballot_count), 1);
    step(1);
    chk("t1_timeout_pulse", 32'(bus.timeout), 0);
    bus.btn_c1 = 1'b0;
    bus.btn_c2 = 1'b0;
    step(12);

    // Bouncing c1: vote timed from the last transition
    arm();
    chk("t2_ready", 32'(bus.ready), 1);
    bus.btn_c1 = 1'b1;
    step(2);
    bus.btn_c1 = 1'b0;
    step(2);
    bus.btn_c1 = 1'b1;
    sb.push_back('{vote: 3'b001, count: 8'd2});
    step(7);
    chk("t2_vote_early", 32'(vote_vec), 0);
    step(1);
    chk("t2_vote", 32'(vote_vec), 32'(3'b001));
    chk("t2_count", 32'(bus.ballot_count), 2);
    step(17);
    bus.btn_c1 = 1'b0;
    step(10);

    // c1+c3 together: multi_press, no vote, timer keeps running
    arm();
    bus.btn_c1 = 1'b1;
    bus.btn_c3 = 1'b1;
    step(7);
    chk("t3_mp_early", 32'(bus.multi_press), 0);
    step(1);
    chk("t3_mp", 32'(bus.multi_press), 1);
    chk("t3_ready", 32'(bus.ready), 1);
    step(1);
    chk("t3_mp_pulse", 32'(bus.multi_press), 0);
    bus.btn_c1 = 1'b0;
    bus.btn_c3 = 1'b0;
    step(10);
    chk("t3_timeout_early", 32'(bus.timeout), 0);
    step(1);
    chk("t3_timeout", 32'(bus.timeout), 1);
    chk("t3_count", 32'(bus.ballot_count), 2);
    step(2);

    // close_poll in the same cycle as a press event
    arm();
    bus.btn_c3 = 1'b1;
    step(7);
    bus.close_poll = 1'b1;
    step(1);
    bus.close_poll = 1'b0;
    chk("t4_closed", 32'(bus.closed), 1);
    chk("t4_ready", 32'(bus.ready), 0);
    chk("t4_vote", 32'(vote_vec), 0);
    bus.voter_auth = 1'b1;
    step(2);
    bus.voter_auth = 1'b0;
    chk("t4_auth_closed", 32'(bus.ready), 0);
    chk("t4_still_closed", 32'(bus.closed), 1);
    chk("t4_count", 32'(bus.ballot_count), 2);

    // Reset out of CLOSED, then reset while ARMED mid-debounce
    rst_n = 1'b0;
    #1;
    chk("t5_rst_closed", 32'(bus.closed), 0);
    chk("t5_rst_count", 32'(bus.ballot_count), 0);
    bus.btn_c3 = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(12);
    arm();
    chk("t5_ready", 32'(bus.ready), 1);
    bus.btn_c1 = 1'b1;
    step(4);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(bus.ready), 0);
    step(1);
    rst_n = 1'b1;
    step(12);
    chk("t5_no_auto_arm", 32'(bus.ready), 0);
    arm();
    chk("t5_rearm", 32'(bus.ready), 1);
    step(10);
    bus.btn_c1 = 1'b0;
    step(12);
    chk("t5_held_no_vote", 32'(bus.ballot_count), 0);
    chk("t5_timed_out", 32'(bus.ready), 0);

    // Fill to saturation, rotating candidates
    for (int k = 0; k < 255; k++) begin
      logic [2:0] b;
      arm();
      chk("sat_arm", 32'(bus.ready), 1);
      b = 3'b001 << (k % 3);
      bus.btn_c1 = b[0];
      bus.btn_c2 = b[1];
      bus.btn_c3 = b[2];
      sb.push_back('{vote: b, count: 8'(k + 1)});
      step(17);
    end
    chk("sat_count", 32'(bus.ballot_count), 255);
    bus.btn_c1 = 1'b0;
    bus.btn_c2 = 1'b0;
    bus.btn_c3 = 1'b0;
    arm();
    chk("sat_auth_ignored", 32'(bus.ready), 0);
    step(1);
    chk("sat_count_hold", 32'(bus.ballot_count), 255);
    chk("sb_empty", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
